slice_scheduler: RTL and testbench
==================================

Name: slice_scheduler

Overview:
Round-robin time-slice arbiter that shares one counted resource among N requesters. It grants one requester at a time and counts that owner's slice with an internal CNT_W-bit counter. A grant ends when the owner drops its request or the slice quantum expires. It sits in front of counter/timer datapaths and sequences which client may drive them.

Parameters:
N, 4, number of requesters (2..16)
CNT_W, 8, width of slice counter and quantum
ID_W, $clog2(N), width of grant_id (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  global enable; low freezes slice counting and blocks new grants
req  input  N  per-requester request, level-sensitive
quantum  input  CNT_W  slice length in cycles, sampled at grant edge
grant  output  N  one-hot grant, registered
grant_id  output  ID_W  index of current/last owner
busy  output  1  high while any grant is active (== |grant)
slice_cnt  output  CNT_W  cycles elapsed in current slice
expired  output  1  one-cycle pulse: slice ended by quantum expiry

Behaviour:
- Reset (async, immediate, no clock needed): grant=0, grant_id=0, busy=0, slice_cnt=0, expired=0, state=IDLE, internal q_lat=1, rr pointer last=N-1 (req[0] has top priority first).
- States: IDLE, GRANT.
- IDLE, at each rising edge: if en && |req, pick first set req index scanning last+1, last+2, ... wrapping mod N. Then grant[i]=1, grant_id=i, last=i, slice_cnt=0, q_lat=(quantum==0)?1:quantum, state=GRANT. Otherwise stay IDLE.
- Grant latency: req seen high at edge E -> grant high after E (one edge).
- GRANT, at each rising edge, in priority order:
  1. req[grant_id]==0 -> early release: grant=0, slice_cnt=0, expired=0, state=IDLE. This takes priority even if the quantum is reached on the same edge, and applies even when en=0.
  2. else if en==0 -> hold: slice_cnt, grant and q_lat unchanged.
  3. else if slice_cnt==q_lat-1 -> expiry: grant=0, slice_cnt=0, expired=1 for exactly this next cycle, state=IDLE.
  4. else slice_cnt=slice_cnt+1.
- With request held and en high, grant stays high exactly q_lat cycles, with slice_cnt values 0..q_lat-1.
- After any release, grant is low for at least one cycle, because IDLE re-arbitrates on the following edge. A continuously requesting sole requester gets q cycles on, 1 off.
- quantum is sampled only at the grant edge; changes during a slice are ignored. quantum=0 yields a 1-cycle slice. quantum=2^CNT_W-1 is the maximum; slice_cnt never wraps.
- grant_id retains the last owner while IDLE. busy is combinational from grant.
- expired is low at all times except the single cycle after an expiry edge.
- Requests from non-owners during GRANT are ignored until IDLE; no preemption.
- rst asserted mid-slice: all outputs clear asynchronously; the rr pointer returns to N-1.

Test Plan:
1. Single requester: rst release, en=1, quantum=3, req=4'b0001 held -> grant=0001 one edge later, high 3 cycles (slice_cnt 0,1,2). expired=1 in the cycle grant falls. grant low 1 cycle, then regranted.
2. Round robin: req=4'b1111, quantum=2 -> grant_id sequence 0,1,2,3,0. Each grant lasts 2 cycles, separated by 1 idle cycle, with 4 expired pulses per round.
3. Early release: quantum=10, req[1] only, drop req[1] when slice_cnt=4 -> grant falls next edge, slice_cnt=0, expired never pulses. Dropping at slice_cnt=9 also gives expired=0.
4. Freeze: quantum=5, deassert en for 3 cycles while slice_cnt=2 -> slice_cnt holds at 2, grant stays, total grant length 8 cycles. en=0 in IDLE with req=0010 -> no grant.
5. Quantum sampling: grant with quantum=4, change quantum to 1 mid-slice -> slice still 4 cycles. quantum=0 -> 1-cycle grant with expired.
6. Async reset: assert rst mid-grant between edges -> grant, busy, slice_cnt clear without a clock edge. After release with req=4'b0101 -> first grant to index 0, then 2.

Source files
------------

// File: rtl/slice_scheduler.sv
// Round-robin time-slice arbiter: one owner at a time, each grant bounded by a
// quantum latched at the grant edge, or cut short when the owner drops its request.
module slice_scheduler #(
    parameter int N     = 4,
    parameter int CNT_W = 8,
    localparam int ID_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic [CNT_W-1:0] quantum,
    output logic [N-1:0]     grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic [CNT_W-1:0] slice_cnt,
    output logic             expired
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_reg, state_next;
    logic [N-1:0]      grant_reg, grant_next;
    logic [ID_W-1:0]   grant_id_reg, grant_id_next;
    logic [ID_W-1:0]   last_reg, last_next;
    logic [CNT_W-1:0]  slice_cnt_reg, slice_cnt_next;
    logic [CNT_W-1:0]  q_lat_reg, q_lat_next;
    logic              expired_reg, expired_next;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [N-1:0]      pick_onehot;

    // Rotating priority scan: the slot after the last owner is looked at first.
    always_comb begin : arbiter
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin : fsm_next
        state_next     = state_reg;
        grant_next     = grant_reg;
        grant_id_next  = grant_id_reg;
        last_next      = last_reg;
        slice_cnt_next = slice_cnt_reg;
        q_lat_next     = q_lat_reg;
        expired_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en && pick_valid) begin
                    grant_next     = pick_onehot;
                    grant_id_next  = pick_id;
                    last_next      = pick_id;
                    slice_cnt_next = '0;
                    q_lat_next     = (quantum == '0) ? CNT_W'(1) : quantum;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                // Owner release wins over both freeze and quantum expiry.
                if (!req[grant_id_reg]) begin
                    grant_next     = '0;
                    slice_cnt_next = '0;
                    state_next     = IDLE;
                end else if (!en) begin
                    state_next = GRANT;
                end else if (slice_cnt_reg == q_lat_reg - CNT_W'(1)) begin
                    grant_next     = '0;
                    slice_cnt_next = '0;
                    expired_next   = 1'b1;
                    state_next     = IDLE;
                end else begin
                    slice_cnt_next = slice_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                grant_next     = '0;
                slice_cnt_next = '0;
                state_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_id_reg  <= '0;
            last_reg      <= ID_W'(N - 1);
            slice_cnt_reg <= '0;
            q_lat_reg     <= CNT_W'(1);
            expired_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            grant_id_reg  <= grant_id_next;
            last_reg      <= last_next;
            slice_cnt_reg <= slice_cnt_next;
            q_lat_reg     <= q_lat_next;
            expired_reg   <= expired_next;
        end
    end

    assign grant     = grant_reg;
    assign grant_id  = grant_id_reg;
    assign busy      = |grant_reg;
    assign slice_cnt = slice_cnt_reg;
    assign expired   = expired_reg;

endmodule

// File: tb/tb_slice_scheduler.sv
// Bench for slice_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a slice-level behavioural model.
module tb_slice_scheduler;

    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int ID_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [N-1:0]     req;
    logic [CNT_W-1:0] quantum;
    logic [N-1:0]     grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic [CNT_W-1:0] slice_cnt;
    logic             expired;

    slice_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .quantum(quantum),
        .grant(grant), .grant_id(grant_id), .busy(busy),
        .slice_cnt(slice_cnt), .expired(expired)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: who owns the resource (-1 = nobody), how long it has held it,
    // how long it may hold it, and who owned it last.
    int m_owner, m_id, m_last, m_elapsed, m_len;
    bit m_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_id = 0; m_last = N - 1; m_elapsed = 0; m_len = 1; m_exp = 0;
    endtask

    task automatic model_edge();
        m_exp = 0;
        if (m_owner < 0) begin
            if (en && req != 0) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last + k) % N;
                    if (req[i]) begin
                        m_owner = i; m_id = i; m_last = i; m_elapsed = 0;
                        m_len = (quantum == 0) ? 1 : int'(quantum);
                        break;
                    end
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1; m_elapsed = 0;
        end else if (en) begin
            if (m_elapsed + 1 == m_len) begin
                m_owner = -1; m_elapsed = 0; m_exp = 1;
            end else begin
                m_elapsed++;
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        chk("grant", 32'(grant), 32'(eg));
        chk("grant_id", 32'(grant_id), 32'(m_id));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("slice_cnt", 32'(slice_cnt), 32'(m_elapsed));
        chk("expired", 32'(expired), 32'(m_exp));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (grant == '0 && n < 20) begin
            step();
            n++;
        end
        chk("wait_grant_timeout", 32'(grant != '0), 32'd1);
    endtask

    task automatic measure_slice(output int len, output bit exp_at_end);
        len = 1;
        step();
        while (grant != '0 && len < 600) begin
            len++;
            step();
        end
        exp_at_end = expired;
    endtask

    int len, n, exp_cnt;
    bit ex;
    logic [ID_W-1:0] ids[$];
    logic [N-1:0] prev_grant;

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; quantum = '0;
        model_reset();
        #2;
        check_all();
        step();
        rst = 1'b0;

        // Single requester, quantum 3
        en = 1'b1; quantum = 8'd3; req = 4'b0001;
        step();
        chk("t1_grant", 32'(grant), 32'h1);
        measure_slice(len, ex);
        chk("t1_len", 32'(len), 32'd3);
        chk("t1_expired", 32'(ex), 32'd1);
        step();
        chk("t1_regrant", 32'(grant), 32'h1);

        // Round robin over all four
        do_reset();
        req = 4'b1111; quantum = 8'd2;
        exp_cnt = 0; prev_grant = '0; n = 0;
        while (ids.size() < 5 && n < 60) begin
            step();
            if (expired) exp_cnt++;
            if (grant != '0 && prev_grant == '0) ids.push_back(grant_id);
            prev_grant = grant;
            n++;
        end
        chk("t2_count", 32'(ids.size()), 32'd5);
        for (int i = 0; i < 5 && i < ids.size(); i++) begin
            chk("t2_id", 32'(ids[i]), 32'(i % N));
        end
        chk("t2_expired_pulses", 32'(exp_cnt), 32'd4);

        // Early release at slice_cnt 4 and 9
        do_reset();
        req = 4'b0010; quantum = 8'd10;
        for (int j = 0; j < 2; j++) begin
            n = 0;
            while (!(grant != '0 && slice_cnt == CNT_W'(j == 0 ? 4 : 9)) && n < 30) begin
                step();
                n++;
            end
            chk("t3_reached", 32'(slice_cnt), 32'(j == 0 ? 4 : 9));
            req = 4'b0000;
            step();
            chk("t3_grant", 32'(grant), 32'h0);
            chk("t3_cnt", 32'(slice_cnt), 32'h0);
            chk("t3_expired", 32'(expired), 32'h0);
            req = 4'b0010;
        end

        // Freeze mid-slice
        req = 4'b0000; step(); step();
        req = 4'b0010; quantum = 8'd5;
        wait_grant();
        len = 1;
        while (slice_cnt != 8'd2 && len < 10) begin
            step();
            len++;
        end
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            len++;
            chk("t4_hold", 32'(slice_cnt), 32'd2);
        end
        en = 1'b1;
        step();
        while (grant != '0 && len < 40) begin
            len++;
            step();
        end
        chk("t4_len", 32'(len), 32'd8);
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t4_idle_blocked", 32'(grant), 32'h0);
        end
        en = 1'b1;

        // Quantum latched at grant edge; quantum 0 gives one cycle
        req = 4'b0000; step(); step();
        quantum = 8'd4; req = 4'b0001;
        wait_grant();
        quantum = 8'd1;
        measure_slice(len, ex);
        chk("t5_len4", 32'(len), 32'd4);
        req = 4'b0000; step(); step();
        quantum = 8'd0; req = 4'b0001;
        wait_grant();
        measure_slice(len, ex);
        chk("t5_len1", 32'(len), 32'd1);
        chk("t5_expired", 32'(ex), 32'd1);

        // Asynchronous reset between edges
        req = 4'b0101; quantum = 8'd5;
        wait_grant();
        step(); step();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t6_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        wait_grant();
        chk("t6_first", 32'(grant_id), 32'd0);
        measure_slice(len, ex);
        wait_grant();
        chk("t6_second", 32'(grant_id), 32'd2);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            req     = N'($urandom);
            en      = ($urandom_range(0, 7) != 0);
            quantum = CNT_W'($urandom_range(0, 6));
            rst     = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
